// File: rtl/viterbi_pkg.sv
// Shared types and the trellis predecessor function for the K=3 (4-state) Viterbi decoder.
package viterbi_pkg;
    localparam int NUM_STATES = 4;
    localparam int STATE_W    = 2;

    typedef logic [NUM_STATES-1:0] decision_t;

    typedef enum logic [1:0] {
        COLLECT,
        TRACE,
        OUTPUT
    } tb_fsm_e;

    // Survivor into state s came from {s[0], d[s]}.
    function automatic logic [STATE_W-1:0] tb_pred(input logic [STATE_W-1:0] state,
                                                   input decision_t decision);
        return {state[0], decision[state]};
    endfunction
endpackage

// File: rtl/survivor_mem.sv
// Survivor decision storage: one write port, one combinational read port.
module survivor_mem
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  decision_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output decision_t        rd_data
);
    decision_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/viterbi_traceback_unit.sv
// Survivor memory + traceback: collects one frame of ACS decisions, traces back from
// state 0 and streams the decoded bits in forward order with the tail dropped.
//   state   | meaning
//   COLLECT | accepting decision vectors into survivor memory
//   TRACE   | walking back one step per cycle, filling the lifo
//   OUTPUT  | streaming lifo[0 .. len-TAIL_LEN-1] over valid/ready
module viterbi_traceback_unit
    import viterbi_pkg::*;
#(
    parameter int MAX_FRAME = 64,
    parameter int TAIL_LEN  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dec_valid,
    input  logic [NUM_STATES-1:0] i_decision,
    input  logic                  i_dec_last,
    output logic                  o_dec_ready,
    output logic                  o_bit_valid,
    output logic                  o_bit,
    output logic                  o_bit_last,
    input  logic                  i_bit_ready,
    output logic                  o_busy,
    output logic                  o_overflow
);
    localparam int PTR_W = $clog2(MAX_FRAME);
    localparam int LEN_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] TAIL_L = LEN_W'(TAIL_LEN);

    tb_fsm_e              state, state_nxt;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, out_idx;
    logic [LEN_W-1:0]     len, last_idx;
    logic [STATE_W-1:0]   tb_state;
    logic [MAX_FRAME-1:0] lifo;
    decision_t            rd_data;
    logic                 wr_en, last_step, out_fire;

    survivor_mem #(.DEPTH(MAX_FRAME), .PTR_W(PTR_W)) u_mem (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_decision),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign o_dec_ready = (state == COLLECT);
    assign o_busy      = (state != COLLECT);
    assign wr_en       = o_dec_ready && i_dec_valid;
    assign last_step   = i_dec_last || (wr_ptr == PTR_W'(MAX_FRAME - 1));
    assign out_fire    = o_bit_valid && i_bit_ready;
    assign last_idx    = len - LEN_W'(TAIL_LEN + 1);
    // Gated by valid so both read 0 outside a transfer; stable while stalled.
    assign o_bit       = o_bit_valid && lifo[out_idx];
    assign o_bit_last  = o_bit_valid && ({1'b0, out_idx} == last_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (wr_en && last_step) state_nxt = TRACE;
            TRACE:   if (rd_ptr == '0) state_nxt = (len > TAIL_L) ? OUTPUT : COLLECT;
            OUTPUT:  if (out_fire && o_bit_last) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= COLLECT;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_idx     <= '0;
            len         <= '0;
            tb_state    <= '0;
            o_bit_valid <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_overflow <= 1'b0;
            case (state)
                COLLECT: begin
                    if (wr_en) begin
                        if (last_step) begin
                            wr_ptr     <= '0;
                            len        <= {1'b0, wr_ptr} + LEN_W'(1);
                            tb_state   <= '0;
                            rd_ptr     <= wr_ptr;
                            o_overflow <= !i_dec_last;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                TRACE: begin
                    tb_state <= tb_pred(tb_state, rd_data);
                    rd_ptr   <= rd_ptr - PTR_W'(1);
                    if (rd_ptr == '0) begin
                        out_idx     <= '0;
                        o_bit_valid <= (len > TAIL_L);
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        if (o_bit_last) o_bit_valid <= 1'b0;
                        else            out_idx     <= out_idx + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Traceback yields bits newest-first; indexing by step restores forward order.
    always_ff @(posedge i_clk) begin
        if (state == TRACE) lifo[rd_ptr] <= tb_state[1];
    end
endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// Self-checking bench: frames are built from known information bits by encoding them
// through the trellis, and the decoded stream is compared against a scoreboard queue.
module tb_viterbi_traceback_unit;
    import viterbi_pkg::*;

    localparam int TAIL = 2;

    logic      i_clk = 1'b0;
    logic      i_rst, i_dec_valid, i_dec_last;
    logic      i_bit_ready = 1'b1;
    decision_t i_decision;
    logic      o_dec_ready, o_bit_valid, o_bit, o_bit_last, o_busy, o_overflow;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q [$];
    logic [1:0] exp_item;
    int         ready_mode = 0;
    int         rcnt = 0;
    int         ovf_cnt = 0;
    int         ready_viol = 0;
    logic       prev_hold = 1'b0;
    logic       prev_bit, prev_last;

    typedef struct {
        int          len;
        logic [63:0] info;
        bit          rnd;
        bit          use_last;
        int          rmode;
    } vec_t;
    vec_t vecs [10];

    always #5 i_clk = ~i_clk;

    viterbi_traceback_unit dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_dec_valid (i_dec_valid),
        .i_decision  (i_decision),
        .i_dec_last  (i_dec_last),
        .o_dec_ready (o_dec_ready),
        .o_bit_valid (o_bit_valid),
        .o_bit       (o_bit),
        .o_bit_last  (o_bit_last),
        .i_bit_ready (i_bit_ready),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready pattern 1,0,0,1 repeating in mode 1; held low in mode 2.
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_bit_ready = 1'b1;
            1: begin
                i_bit_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                rcnt++;
            end
            default: i_bit_ready = 1'b0;
        endcase
    end

    always @(negedge i_clk) begin
        if (o_overflow) ovf_cnt++;
        if (o_busy && o_dec_ready) ready_viol++;
        if (i_rst) begin
            prev_hold = 1'b0;
        end else if (o_bit_valid) begin
            if (prev_hold) begin
                check("hold_bit", o_bit, prev_bit);
                check("hold_last", o_bit_last, prev_last);
            end
            if (i_bit_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", o_bit_valid, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("bit", o_bit, exp_item[1]);
                    check("bit_last", o_bit_last, exp_item[0]);
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_bit  = o_bit;
                prev_last = o_bit_last;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_bit_valid"}, o_bit_valid, 0);
        check({tag, "_bit"}, o_bit, 0);
        check({tag, "_bit_last"}, o_bit_last, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_overflow"}, o_overflow, 0);
        check({tag, "_dec_ready"}, o_dec_ready, 1);
    endtask

    // Encode info bits (tail forced to 0) and emit the ACS decisions that lead there;
    // non-survivor bits are optionally randomised.
    task automatic drive_frame(input int len, input logic [63:0] info, input bit rnd,
                               input bit use_last);
        logic [1:0] s, nx;
        logic       u;
        decision_t  d;
        int         w;
        w = 0;
        while (!o_dec_ready && w < 500) begin
            @(posedge i_clk); #1;
            w++;
        end
        check("ready_before_frame", o_dec_ready, 1);
        s = 2'b00;
        for (int k = 0; k < len; k++) begin
            u  = (k >= len - TAIL) ? 1'b0 : info[k];
            nx = {u, s[1]};
            d  = rnd ? decision_t'($urandom) : '0;
            d[nx] = s[0];
            if (k < len - TAIL) exp_q.push_back({u, (k == len - TAIL - 1)});
            i_dec_valid = 1'b1;
            i_decision  = d;
            i_dec_last  = use_last && (k == len - 1);
            @(posedge i_clk); #1;
            s = nx;
        end
        i_dec_valid = 1'b0;
        i_dec_last  = 1'b0;
        i_decision  = decision_t'($urandom);
    endtask

    task automatic run_frame(input vec_t v);
        int ov0, n, w;
        ov0        = ovf_cnt;
        ready_viol = 0;
        ready_mode = v.rmode;
        drive_frame(v.len, v.info, v.rnd, v.use_last);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (o_busy && !o_bit_valid) n++;
            else break;
        end
        check("trace_cycles", n, v.len);
        if (v.len <= TAIL) begin
            check("short_no_valid", o_bit_valid, 0);
            check("short_ready_back", o_dec_ready, 1);
        end
        w = 0;
        while ((exp_q.size() != 0 || o_busy) && w < 3000) begin
            @(negedge i_clk);
            w++;
        end
        check("frame_done", (exp_q.size() == 0) && !o_busy, 1);
        repeat (3) @(negedge i_clk);
        check("overflow_pulses", ovf_cnt - ov0, v.use_last ? 0 : 1);
        check("ready_low_while_busy", ready_viol, 0);
        @(posedge i_clk); #1;
        ready_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int w;
        vecs[0] = '{8,  64'h0,                   1'b0, 1'b1, 0};
        vecs[1] = '{6,  64'hD,                   1'b0, 1'b1, 0};
        vecs[2] = '{6,  64'hD,                   1'b1, 1'b1, 0};
        vecs[3] = '{6,  64'hD,                   1'b0, 1'b1, 1};
        vecs[4] = '{64, 64'h3A5C_96F0_1E7B_D248, 1'b1, 1'b0, 1};
        vecs[5] = '{1,  64'h0,                   1'b0, 1'b1, 0};
        vecs[6] = '{2,  64'h3,                   1'b1, 1'b1, 0};
        vecs[7] = '{3,  64'h1,                   1'b1, 1'b1, 1};
        vecs[8] = '{64, 64'hF0F0_1234_8765_ABCD, 1'b1, 1'b1, 0};
        vecs[9] = '{20, 64'h5_A3C9,              1'b1, 1'b1, 1};

        i_rst = 1'b1; i_dec_valid = 1'b0; i_dec_last = 1'b0; i_decision = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_idle("reset");

        for (int i = 0; i < 10; i++) run_frame(vecs[i]);

        // Reset in the middle of TRACE: frame is abandoned, nothing emitted.
        drive_frame(10, 64'h2D, 1'b1, 1'b1);
        repeat (3) @(posedge i_clk);
        #1;
        check("busy_in_trace", o_busy, 1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_q.delete();
        check_idle("rst_trace");
        repeat (20) @(posedge i_clk);
        #1;
        run_frame(vecs[1]);

        // Reset while OUTPUT is stalled by the sink.
        ready_mode = 2;
        drive_frame(6, 64'hD, 1'b1, 1'b1);
        w = 0;
        while (!o_bit_valid && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        check("valid_in_stall", o_bit_valid, 1);
        repeat (3) @(negedge i_clk);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        ready_mode = 0;
        exp_q.delete();
        check_idle("rst_output");
        repeat (10) @(posedge i_clk);
        #1;
        run_frame(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
